// File: rtl/clint_mmio_ctrl.sv
// Core-local interruptor: 64-bit mtime with prescaler, per-hart mtimecmp/msip,
// a 32-bit valid/ready MMIO slave and registered mip_mtip/mip_msip outputs.
module clint_mmio_ctrl #(
  parameter int unsigned NHARTS   = 1,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_addr,
  input  logic              req_we,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic              time_inhibit,
  output logic [63:0]       mtime_o,
  output logic [NHARTS-1:0] mip_mtip,
  output logic [NHARTS-1:0] mip_msip
);

  localparam int unsigned   PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [12:0]   MTIME_DWORD = 13'h17FF;
  localparam logic [12:0]   CMP_DWORD   = 13'h0800;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [63:0]       r_mtime;
  logic [PW-1:0]     r_presc;
  logic [63:0]       r_mtimecmp [NHARTS];
  logic [NHARTS-1:0] r_msip;
  logic [NHARTS-1:0] r_mtip;
  logic [NHARTS-1:0] r_msip_q;

  logic              w_accept;
  logic              w_wr;
  logic              w_hi;
  logic              w_mtime_sel;
  logic [NHARTS-1:0] w_msip_sel;
  logic [NHARTS-1:0] w_cmp_sel;
  logic              w_hit;
  logic [31:0]       w_rdata;
  logic              w_unused;

  // Byte-lane merge of write data into an existing 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_wr        = w_accept && req_we;
  assign w_hi        = req_addr[2];
  assign w_mtime_sel = (req_addr[15:3] == MTIME_DWORD);
  assign w_unused    = ^req_addr[1:0];

  // Address decode and read mux; anything not selected is an error.
  always_comb begin
    w_msip_sel = '0;
    w_cmp_sel  = '0;
    w_hit      = w_mtime_sel;
    w_rdata    = '0;
    if (w_mtime_sel) w_rdata = w_hi ? r_mtime[63:32] : r_mtime[31:0];
    for (int unsigned h = 0; h < NHARTS; h++) begin
      w_msip_sel[h] = (req_addr[15:2] == 14'(h));
      w_cmp_sel[h]  = (req_addr[15:3] == (CMP_DWORD + 13'(h)));
      if (w_msip_sel[h]) begin
        w_hit   = 1'b1;
        w_rdata = {31'd0, r_msip[h]};
      end
      if (w_cmp_sel[h]) begin
        w_hit   = 1'b1;
        w_rdata = w_hi ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid)  w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake state and the response captured at accept time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_rdata <= (req_we || !w_hit) ? 32'd0 : w_rdata;
        r_err   <= !w_hit;
      end
    end
  end

  // A bus write to either mtime half beats the tick and restarts the prescaler.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mtime <= '0;
      r_presc <= '0;
    end else if (w_wr && w_mtime_sel) begin
      r_presc <= '0;
      if (w_hi) r_mtime[63:32] <= merge_bytes(r_mtime[63:32], req_wdata, req_wstrb);
      else      r_mtime[31:0]  <= merge_bytes(r_mtime[31:0], req_wdata, req_wstrb);
    end else if (!time_inhibit) begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_mtime <= r_mtime + 64'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_msip <= '0;
      for (int unsigned h = 0; h < NHARTS; h++) r_mtimecmp[h] <= '1;
    end else if (w_wr) begin
      for (int unsigned h = 0; h < NHARTS; h++) begin
        if (w_msip_sel[h] && req_wstrb[0]) r_msip[h] <= req_wdata[0];
        if (w_cmp_sel[h]) begin
          if (w_hi) r_mtimecmp[h][63:32] <= merge_bytes(r_mtimecmp[h][63:32], req_wdata, req_wstrb);
          else      r_mtimecmp[h][31:0]  <= merge_bytes(r_mtimecmp[h][31:0], req_wdata, req_wstrb);
        end
      end
    end
  end

  // Interrupt-pending outputs lag the architectural state by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mtip   <= '0;
      r_msip_q <= '0;
    end else begin
      for (int unsigned h = 0; h < NHARTS; h++) r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
      r_msip_q <= r_msip;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mtime_o    = r_mtime;
  assign mip_mtip   = r_mtip;
  assign mip_msip   = r_msip_q;

endmodule

// File: tb/tb_clint_mmio_ctrl.sv
// Directed bench: a 2-hart TICK_DIV=1 instance for bus/timer behaviour and a
// 1-hart TICK_DIV=4 instance for prescaler and time_inhibit.
module tb_clint_mmio_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b;
  logic        req_valid, req_we, resp_ready, time_inhibit, b_inhibit;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [63:0] mtime_o;
  logic [1:0]  mip_mtip, mip_msip;

  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [63:0] b_mtime;
  logic [0:0]  b_mtip, b_msip;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int unsigned exp_b [15] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3};

  clint_mmio_ctrl #(.NHARTS(2), .TICK_DIV(1)) u_dut (
    .clock(clock), .reset(rst_a),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .time_inhibit(time_inhibit), .mtime_o(mtime_o),
    .mip_mtip(mip_mtip), .mip_msip(mip_msip)
  );

  clint_mmio_ctrl #(.NHARTS(1), .TICK_DIV(4)) u_dut_div4 (
    .clock(clock), .reset(rst_b),
    .req_valid(1'b0), .req_ready(b_req_ready), .req_addr(16'h0000),
    .req_we(1'b0), .req_wdata(32'h0), .req_wstrb(4'h0),
    .resp_valid(b_resp_valid), .resp_ready(1'b1), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .time_inhibit(b_inhibit), .mtime_o(b_mtime),
    .mip_mtip(b_mtip), .mip_msip(b_msip)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction from IDLE with resp_ready high; samples the response cycle.
  task automatic bus(input logic [15:0] a, input logic we, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd, output logic er,
                     output logic [1:0] mt, output logic [1:0] ms);
    req_addr  = a;
    req_we    = we;
    req_wdata = wd;
    req_wstrb = ws;
    req_valid = 1'b1;
    @(negedge clock);
    chk("bus_resp_valid", resp_valid, 1);
    rd = resp_rdata;
    er = resp_err;
    mt = mip_mtip;
    ms = mip_msip;
    req_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [1:0]  mt, ms;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1; time_inhibit = 0; b_inhibit = 0; rst_a = 0; rst_b = 0;
    repeat (3) @(negedge clock);
    rst_a = 1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_mtime", mtime_o, 0);
    chk("rst_mtip", mip_mtip, 0);
    chk("rst_msip", mip_msip, 0);

    // mtime read returns the value present in the accept cycle
    repeat (2) @(negedge clock);
    bus(16'hBFF8, 0, 0, 0, rd, er, mt, ms);
    chk("rd_mtime_lo", rd, 2);
    chk("rd_mtime_err", er, 0);
    chk("rd_mtime_mtip", mt, 0);
    chk("mtime_after_rd", mtime_o, 4);

    // frozen timer: load mtime=0, mtimecmp[0]=0x10
    time_inhibit = 1;
    bus(16'hBFF8, 1, 32'h0, 4'hF, rd, er, mt, ms);
    bus(16'hBFFC, 1, 32'h0, 4'hF, rd, er, mt, ms);
    bus(16'h4000, 1, 32'h10, 4'hF, rd, er, mt, ms);
    bus(16'h4004, 1, 32'h0, 4'hF, rd, er, mt, ms);
    chk("inhibit_mtime", mtime_o, 0);
    chk("cmp_loaded_mtip", mip_mtip, 0);
    time_inhibit = 0;
    repeat (16) @(negedge clock);
    chk("mtime_at_cmp", mtime_o, 64'h10);
    chk("mtip_not_yet", mip_mtip, 2'b00);
    @(negedge clock);
    chk("mtip_rise", mip_mtip, 2'b01);
    bus(16'h4004, 1, 32'hFFFF_FFFF, 4'hF, rd, er, mt, ms);
    chk("mtip_hold_commit", mt, 2'b01);
    chk("mtip_fall", mip_mtip, 2'b00);

    // mtime write collides with an increment; write wins, then carry into hi
    bus(16'hBFFC, 1, 32'h0, 4'hF, rd, er, mt, ms);
    req_addr = 16'hBFF8; req_we = 1; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    req_valid = 1;
    @(negedge clock);
    chk("mtime_write_wins", mtime_o, 64'h0000_0000_FFFF_FFFF);
    req_valid = 0;
    @(negedge clock);
    chk("mtime_carry", mtime_o, 64'h0000_0001_0000_0000);

    // msip, error decode and byte strobes
    bus(16'h0004, 1, 32'h1, 4'b0001, rd, er, mt, ms);
    chk("msip_lag", ms, 2'b00);
    chk("msip_set", mip_msip, 2'b10);
    bus(16'h0004, 0, 0, 0, rd, er, mt, ms);
    chk("rd_msip1", rd, 1);
    chk("rd_msip1_err", er, 0);
    bus(16'h0008, 0, 0, 0, rd, er, mt, ms);
    chk("rd_unmapped_data", rd, 0);
    chk("rd_unmapped_err", er, 1);
    bus(16'h0008, 1, 32'hFFFF_FFFF, 4'hF, rd, er, mt, ms);
    chk("wr_unmapped_err", er, 1);
    chk("wr_unmapped_msip", mip_msip, 2'b10);
    bus(16'h4010, 1, 32'h0, 4'hF, rd, er, mt, ms);
    chk("wr_cmp2_err", er, 1);
    bus(16'h4000, 0, 0, 0, rd, er, mt, ms);
    chk("cmp0_lo_intact", rd, 32'h10);
    bus(16'h0004, 1, 32'h0, 4'b1110, rd, er, mt, ms);
    chk("msip_strb_err", er, 0);
    bus(16'h0007, 0, 0, 0, rd, er, mt, ms);
    chk("msip_strb_kept", rd, 1);
    bus(16'h4008, 1, 32'h1234_5678, 4'b0101, rd, er, mt, ms);
    chk("wr_rdata_zero", rd, 0);
    bus(16'h4008, 0, 0, 0, rd, er, mt, ms);
    chk("cmp1_lo_bytes", rd, 32'hFF34_FF78);
    bus(16'h400C, 0, 0, 0, rd, er, mt, ms);
    chk("cmp1_hi_intact", rd, 32'hFFFF_FFFF);
    bus(16'hBFFC, 0, 0, 0, rd, er, mt, ms);
    chk("rd_mtime_hi", rd, 1);

    // stalled response, then async reset in RESP
    resp_ready = 0;
    req_addr = 16'h0004; req_we = 0; req_valid = 1;
    @(negedge clock);
    chk("stall_valid", resp_valid, 1);
    chk("stall_ready", req_ready, 0);
    chk("stall_rdata", resp_rdata, 1);
    req_addr = 16'h4008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_hold_valid", resp_valid, 1);
      chk("stall_hold_ready", req_ready, 0);
      chk("stall_hold_rdata", resp_rdata, 1);
    end
    #2 rst_a = 0;
    #1;
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_rdata", resp_rdata, 0);
    chk("arst_mtime", mtime_o, 0);
    chk("arst_msip", mip_msip, 0);
    @(negedge clock);
    rst_a = 1; req_valid = 0; resp_ready = 1;
    bus(16'h4000, 0, 0, 0, rd, er, mt, ms);
    chk("arst_cmp0", rd, 32'hFFFF_FFFF);
    bus(16'h0004, 0, 0, 0, rd, er, mt, ms);
    chk("arst_msip_rd", rd, 0);

    // TICK_DIV=4 with a 3-cycle inhibit pulse
    @(negedge clock);
    rst_b = 1;
    chk("div4_reset", b_mtime, 0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      chk("div4_mtime", b_mtime, 64'(exp_b[k-1]));
      if (k == 6) b_inhibit = 1;
      if (k == 9) b_inhibit = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
